// File: rtl/data_mem_responder_pkg.sv
// Shared types and address helpers for the MEM-stage data-memory responder.
// Optional feature macro used by the responder: DMEM_ACCESS_ERR_EN.
package dmem_pkg;

   localparam int unsigned      DMEM_DATA_W    = 32;
   localparam logic [31:0]      DMEM_BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   // Word index of a byte address relative to the base; the two low bits drop out.
   function automatic logic [DMEM_DATA_W-1:0] word_index(
      input logic [DMEM_DATA_W-1:0] a,
      input logic [DMEM_DATA_W-1:0] base
   );
      logic [DMEM_DATA_W-1:0] off;
      off = a - base;
      return off >> 2;
   endfunction

   // True when the address lies at or above the base and its word index fits the array.
   function automatic logic in_range(
      input logic [DMEM_DATA_W-1:0] a,
      input logic [DMEM_DATA_W-1:0] base,
      input logic [DMEM_DATA_W-1:0] idx,
      input int unsigned            depth
   );
      return (a >= base) && (idx < depth);
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
   parameter int unsigned DATA_W = dmem_pkg::DMEM_DATA_W
);
   logic              mem_r_en;
   logic              mem_w_en;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              ready;
   logic              err;

   modport master (
      output mem_r_en, mem_w_en, addr, wr_data,
      input  rd_data, ready, err
   );

   modport slave (
      input  mem_r_en, mem_w_en, addr, wr_data,
      output rd_data, ready, err
   );
endinterface

// File: rtl/data_mem_responder_array.sv
// Word RAM backing the data-memory responder: synchronous write, asynchronous read, never cleared.
module dmem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Commit a word on the clock edge when the responder enables the write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wr_data;
      end
   end

   assign rd_data = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: multi-cycle word memory with programmable wait states
// and a one-cycle registered ready pulse.
// Optional feature macro: DMEM_ACCESS_ERR_EN (flags out-of-range / misaligned accesses on err
// and suppresses misaligned writes; without it err is tied low and addr[1:0] is ignored).
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned       DATA_W      = DMEM_DATA_W,
   parameter int unsigned       DEPTH       = 64,
   parameter logic [DATA_W-1:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int unsigned       WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   data_mem_responder_if.slave   bus
);

   localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic             ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_LOAD  = ZERO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rd_q;
   logic              ready_q;
   logic [DATA_W-1:0] widx;
   logic [DATA_W-1:0] arr_rdata;
   logic [IDX_W-1:0]  idx;
   logic              req;
   logic              range_ok;
   logic              misalign;
   logic              commit;
   logic              mem_we;

   // Decode the request and the completing edge (the IDLE/WAIT -> DONE transition).
   always_comb begin
      req      = bus.mem_r_en | bus.mem_w_en;
      widx     = word_index(bus.addr, BASE_ADDR);
      range_ok = in_range(bus.addr, BASE_ADDR, widx, DEPTH);
      idx      = widx[IDX_W-1:0];
`ifdef DMEM_ACCESS_ERR_EN
      misalign = (bus.addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
      commit   = req & (((state == IDLE) & ZERO_WAIT) | ((state == WAIT) & (cnt == '0)));
      // rst gate keeps a zero-wait write from landing on the edge that releases reset
      mem_we   = commit & bus.mem_w_en & range_ok & ~misalign & rst;
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .we      (mem_we),
      .idx     (idx),
      .wr_data (bus.wr_data),
      .rd_data (arr_rdata)
   );

   // Access FSM with wait counter and registered rd_data/ready outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rd_q    <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (ZERO_WAIT) begin
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (commit) begin
            ready_q <= 1'b1;
            rd_q    <= (bus.mem_r_en & ~bus.mem_w_en & range_ok) ? arr_rdata : '0;
         end
      end
   end

`ifdef DMEM_ACCESS_ERR_EN
   logic err_q;

   // Error flag registered alongside ready; low in every non-ready cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= commit & (~range_ok | misalign);
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.rd_data = rd_q;
   assign bus.ready   = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a WAIT_CYCLES=3 instance and a WAIT_CYCLES=0
// instance, checked through a queue-based scoreboard fed by a small memory model.
// Honours DMEM_ACCESS_ERR_EN for the expected err values.
module tb_data_mem_responder;

`ifdef DMEM_ACCESS_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] rd;
      logic        err;
      bit          chk_rd;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   int          n_tests;
   int          n_fail;
   exp_t        sb[$];
   logic [31:0] model [2][64];

   logic [31:0] rd_o    [2];
   logic        ready_o [2];
   logic        err_o   [2];

   data_mem_responder_if #(.DATA_W(32)) bus3 ();
   data_mem_responder_if #(.DATA_W(32)) bus0 ();

   data_mem_responder #(
      .DATA_W      (32),
      .DEPTH       (64),
      .BASE_ADDR   (32'd1024),
      .WAIT_CYCLES (3)
   ) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   data_mem_responder #(
      .DATA_W      (32),
      .DEPTH       (64),
      .BASE_ADDR   (32'd1024),
      .WAIT_CYCLES (0)
   ) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   assign rd_o[0]    = bus3.rd_data;
   assign rd_o[1]    = bus0.rd_data;
   assign ready_o[0] = bus3.ready;
   assign ready_o[1] = bus0.ready;
   assign err_o[0]   = bus3.err;
   assign err_o[1]   = bus0.err;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
      if (sel == 0) begin
         bus3.mem_r_en = r; bus3.mem_w_en = w; bus3.addr = a; bus3.wr_data = wd;
      end else begin
         bus0.mem_r_en = r; bus0.mem_w_en = w; bus0.addr = a; bus0.wr_data = wd;
      end
   endtask

   // One access. cut>0 interrupts it after that many edges (drop request, or reset if by_reset).
   task automatic access(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int cut, input bit by_reset, input string tag);
      logic [31:0] off;
      logic [31:0] widx;
      bit          in_rng;
      bit          mis;
      exp_t        e;
      exp_t        got_e;
      int          n;
      bit          seen;
      off    = a - 32'd1024;
      widx   = off >> 2;
      in_rng = (a >= 32'd1024) && (widx < 64);
      mis    = (a[1:0] != 2'b00);

      @(posedge clk); #1;
      drive(sel, r, w, a, wd);

      if (cut > 0) begin
         repeat (cut) @(posedge clk);
         #1;
         if (by_reset) begin
            rst = 1'b0;
            #1;
            check({tag, "_rst_ready"}, {31'd0, ready_o[sel]}, 32'd0);
            check({tag, "_rst_rdata"}, rd_o[sel], 32'd0);
         end
         drive(sel, 1'b0, 1'b0, a, wd);
         seen = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (ready_o[sel]) seen = 1'b1;
         end
         check({tag, "_no_ready"}, {31'd0, seen}, 32'd0);
         if (by_reset) begin
            @(posedge clk); #1;
            rst = 1'b1;
         end
         return;
      end

      e.rd     = (r && !w && in_rng) ? model[sel][widx[5:0]] : 32'd0;
      e.err    = ERR_EN && (!in_rng || mis);
      e.chk_rd = r;
      e.lat    = (sel == 0) ? 4 : 1;
      sb.push_back(e);
      if (w && in_rng && !(ERR_EN && mis)) model[sel][widx[5:0]] = wd;

      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ready_o[sel]) seen = 1'b1;
      end
      if (!seen) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         void'(sb.pop_front());
         drive(sel, 1'b0, 1'b0, a, wd);
         return;
      end
      got_e = sb.pop_front();
      check({tag, "_latency"}, n, got_e.lat);
      if (got_e.chk_rd) check({tag, "_rdata"}, rd_o[sel], got_e.rd);
      check({tag, "_err"}, {31'd0, err_o[sel]}, {31'd0, got_e.err});
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, a, wd);
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, ready_o[sel]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk     = 1'b0;
      rst     = 1'b0;
      n_tests = 0;
      n_fail  = 0;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("reset_ready", {31'd0, ready_o[s]}, 32'd0);
         check("reset_rdata", rd_o[s], 32'd0);
         check("reset_err",   {31'd0, err_o[s]}, 32'd0);
      end
      rst = 1'b1;

      // basic write/read, 3 wait states
      access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 1'b0, "t1_wr");
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0,        0, 1'b0, "t1_rd");

      // zero wait states
      access(1, 1'b0, 1'b1, 32'd1028, 32'h12345678, 0, 1'b0, "t2_wr");
      access(1, 1'b1, 1'b0, 32'd1028, 32'h0,        0, 1'b0, "t2_rd");

      // aborted write leaves prior value
      access(0, 1'b0, 1'b1, 32'd1032, 32'h5A5A0001, 0, 1'b0, "t3_pre");
      access(0, 1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 2, 1'b0, "t3_abort");
      access(0, 1'b1, 1'b0, 32'd1032, 32'h0,        0, 1'b0, "t3_rd");

      // out of range reads on both sides
      access(0, 1'b1, 1'b0, 32'd1020,          32'h0, 0, 1'b0, "t4_low");
      access(0, 1'b1, 1'b0, 32'd1024 + 4 * 64, 32'h0, 0, 1'b0, "t4_high");
      access(0, 1'b1, 1'b0, 32'd1024 + 4 * 63, 32'h0, 0, 1'b0, "t4_last");

      // reset during a write's wait states
      access(0, 1'b0, 1'b1, 32'd1036, 32'h77770000, 0, 1'b0, "t5_pre");
      access(0, 1'b1, 1'b0, 32'd1036, 32'h0,        0, 1'b0, "t5_prerd");
      access(0, 1'b0, 1'b1, 32'd1036, 32'h11112222, 2, 1'b1, "t5_reset");
      access(0, 1'b1, 1'b0, 32'd1036, 32'h0,        0, 1'b0, "t5_rd");

      // simultaneous read and write behaves as a write
      access(0, 1'b1, 1'b1, 32'd1040, 32'h0F0F0F0F, 0, 1'b0, "t6_both");
      access(0, 1'b1, 1'b0, 32'd1040, 32'h0,        0, 1'b0, "t6_rd");

      // misaligned write and read
      access(0, 1'b0, 1'b1, 32'd1044, 32'hCAFEF00D, 0, 1'b0, "t7_pre");
      access(0, 1'b0, 1'b1, 32'd1046, 32'h13572468, 0, 1'b0, "t7_mis_wr");
      access(0, 1'b1, 1'b0, 32'd1044, 32'h0,        0, 1'b0, "t7_rd");
      access(0, 1'b1, 1'b0, 32'd1045, 32'h0,        0, 1'b0, "t7_mis_rd");

      // last in-range word, zero-wait side
      access(1, 1'b0, 1'b1, 32'd1024 + 4 * 63, 32'h600DF00D, 0, 1'b0, "t8_wr");
      access(1, 1'b1, 1'b0, 32'd1024 + 4 * 63, 32'h0,        0, 1'b0, "t8_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
